// File: rtl/ddr_write_arb_pkg.sv
// Shared types and constants for the DDR write-port arbiter.
package ddr_write_arb_pkg;

   // Arbiter FSM: waiting for a request, request presented to DDR, burst running
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      BURST = 2'd2
   } state_t;

   localparam int C_ADDR_W  = 38;
   localparam int C_BURST_W = 8;

   // Width of a channel index; a single-channel build still needs one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ddr_write_arbiter_rr_priority_select.sv
// Round-robin picker: first set request bit strictly after 'last', wrapping.
// Purely combinational so the read-side arbiter can reuse it unchanged.
module rr_priority_select #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Walk offsets from the far end back toward last+1 so the nearest hit is kept
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int off = N; off >= 1; off--) begin
         cand = IW'((int'(last) + off) % N);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/ddr_write_arbiter.sv
// Shares one DDR native write port between g_NUM_REQ write channels with
// round-robin fairness, per-grant ack/done routing and a burst watchdog.
module ddr_write_arbiter
   import ddr_write_arb_pkg::*;
#(
   parameter int g_NUM_REQ        = 2,
   parameter int g_DDR_AXI_DWIDTH = 512,
   parameter int g_TIMEOUT        = 4096
) (
   input  logic                                  sys_clk_i,
   input  logic                                  rstn_i,
   input  logic [g_NUM_REQ-1:0]                  req_i,
   input  logic [C_BURST_W*g_NUM_REQ-1:0]        burst_size_i,
   input  logic [C_ADDR_W*g_NUM_REQ-1:0]         start_addr_i,
   input  logic [g_DDR_AXI_DWIDTH*g_NUM_REQ-1:0] data_i,
   input  logic [g_NUM_REQ-1:0]                  data_rdy_i,
   input  logic                                  write_ackn_i,
   input  logic                                  write_done_i,
   output logic                                  write_req_o,
   output logic [C_BURST_W-1:0]                  burst_size_o,
   output logic [C_ADDR_W-1:0]                   write_start_addr_o,
   output logic [g_DDR_AXI_DWIDTH-1:0]           data_o,
   output logic                                  data_rdy_o,
   output logic [g_NUM_REQ-1:0]                  write_ackn_o,
   output logic [g_NUM_REQ-1:0]                  write_done_o,
   output logic [g_NUM_REQ-1:0]                  grant_o,
   output logic                                  timeout_o
);

   localparam int            IW          = idx_w(g_NUM_REQ);
   localparam int            CW          = $clog2(g_TIMEOUT) + 1;
   localparam logic [CW-1:0] C_CNT_LAST  = CW'(g_TIMEOUT - 1);
   localparam logic [IW-1:0] C_LAST_INIT = IW'(g_NUM_REQ - 1);

   state_t        state;
   logic [IW-1:0] grant_idx;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] pick_idx;
   logic          pick_valid;
   logic [CW-1:0] cnt;
   logic          busy;
   logic          ack_fwd;
   logic          done_fwd;
   logic          expire;

   rr_priority_select #(
      .N  (g_NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req   (req_i),
      .last  (last_grant),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // A grant is live in REQ and BURST; ack only counts while the request is
   // outstanding, and done only counts once the burst has been accepted
   // (either earlier, or by an ack in the very same cycle).
   assign busy     = (state != IDLE);
   assign ack_fwd  = (state == REQ) && write_ackn_i;
   assign done_fwd = write_done_i && ((state == BURST) || ack_fwd);

   // Watchdog fires on the last allowed cycle unless a done lands right there
   assign expire    = busy && (cnt == C_CNT_LAST) && !done_fwd;
   assign timeout_o = expire;

   // Grant decode and per-channel routing of the controller's handshake pulses
   for (genvar k = 0; k < g_NUM_REQ; k++) begin : g_ch
      assign grant_o[k]      = busy && (grant_idx == IW'(k));
      assign write_ackn_o[k] = ack_fwd && grant_o[k];
      assign write_done_o[k] = done_fwd && grant_o[k];
   end

   // Arbitration FSM with registered request, address, burst and watchdog count
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state              <= IDLE;
         grant_idx          <= '0;
         last_grant         <= C_LAST_INIT;
         cnt                <= '0;
         write_req_o        <= 1'b0;
         burst_size_o       <= '0;
         write_start_addr_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state              <= REQ;
                  grant_idx          <= pick_idx;
                  burst_size_o       <= burst_size_i[pick_idx*C_BURST_W +: C_BURST_W];
                  write_start_addr_o <= start_addr_i[pick_idx*C_ADDR_W +: C_ADDR_W];
                  write_req_o        <= 1'b1;
                  cnt                <= '0;
               end
            end
            REQ: begin
               cnt <= cnt + 1'b1;
               if (done_fwd || expire) begin
                  state       <= IDLE;
                  write_req_o <= 1'b0;
                  last_grant  <= grant_idx;
               end else if (ack_fwd) begin
                  state       <= BURST;
                  write_req_o <= 1'b0;
               end
            end
            BURST: begin
               cnt <= cnt + 1'b1;
               if (done_fwd || expire) begin
                  state      <= IDLE;
                  last_grant <= grant_idx;
               end
            end
            default: begin
               state       <= IDLE;
               write_req_o <= 1'b0;
            end
         endcase
      end
   end

   // Zero-latency data path from the granted channel's FIFO; quiet when idle
   always_comb begin
      data_o     = '0;
      data_rdy_o = 1'b0;
      if (busy) begin
         data_o     = data_i[grant_idx*g_DDR_AXI_DWIDTH +: g_DDR_AXI_DWIDTH];
         data_rdy_o = data_rdy_i[grant_idx];
      end
   end

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Scenario bench for ddr_write_arbiter with a round-robin reference model.
module tb_ddr_write_arbiter;

   localparam int N  = 2;
   localparam int DW = 512;
   localparam int TO = 16;

   logic            sys_clk_i = 1'b0;
   logic            rstn_i;
   logic [N-1:0]    req_i;
   logic [8*N-1:0]  burst_size_i;
   logic [38*N-1:0] start_addr_i;
   logic [DW*N-1:0] data_i;
   logic [N-1:0]    data_rdy_i;
   logic            write_ackn_i;
   logic            write_done_i;
   logic            write_req_o;
   logic [7:0]      burst_size_o;
   logic [37:0]     write_start_addr_o;
   logic [DW-1:0]   data_o;
   logic            data_rdy_o;
   logic [N-1:0]    write_ackn_o;
   logic [N-1:0]    write_done_o;
   logic [N-1:0]    grant_o;
   logic            timeout_o;

   int errors = 0;
   int checks = 0;
   int m_last;   // model: channel whose grant ended most recently

   ddr_write_arbiter #(
      .g_NUM_REQ        (N),
      .g_DDR_AXI_DWIDTH (DW),
      .g_TIMEOUT        (TO)
   ) dut (
      .sys_clk_i          (sys_clk_i),
      .rstn_i             (rstn_i),
      .req_i              (req_i),
      .burst_size_i       (burst_size_i),
      .start_addr_i       (start_addr_i),
      .data_i             (data_i),
      .data_rdy_i         (data_rdy_i),
      .write_ackn_i       (write_ackn_i),
      .write_done_i       (write_done_i),
      .write_req_o        (write_req_o),
      .burst_size_o       (burst_size_o),
      .write_start_addr_o (write_start_addr_o),
      .data_o             (data_o),
      .data_rdy_o         (data_rdy_o),
      .write_ackn_o       (write_ackn_o),
      .write_done_o       (write_done_o),
      .grant_o            (grant_o),
      .timeout_o          (timeout_o)
   );

   always #5 sys_clk_i = ~sys_clk_i;

   // Reference: nearest requesting channel after 'last', wrapping; -1 if none
   function automatic int rr_next(input logic [N-1:0] req, input int last);
      for (int off = 1; off <= N; off++) begin
         int k;
         k = (last + off) % N;
         if (((int'(req) >> k) & 1) == 1) return k;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int ch);
      return N'(1) << ch;
   endfunction

   task automatic step();
      @(posedge sys_clk_i);
      #1;
   endtask

   task automatic apply_reset();
      rstn_i       = 1'b0;
      req_i        = '0;
      write_ackn_i = 1'b0;
      write_done_i = 1'b0;
      data_rdy_i   = '0;
      repeat (2) step();
      rstn_i = 1'b1;
      m_last = N - 1;
      step();
   endtask

   task automatic test_reset();
      rstn_i       = 1'b0;
      req_i        = '1;
      data_rdy_i   = '1;
      write_ackn_i = 1'b1;
      write_done_i = 1'b1;
      #1;
      checks++;
      if ({write_req_o, grant_o, burst_size_o, write_start_addr_o, data_rdy_o,
           write_ackn_o, write_done_o, timeout_o} !== '0 || data_o !== '0) begin
         errors++;
         $display("FAIL reset_outputs got req=%0b grant=%b ack=%b done=%b rdy=%0b exp all zero",
                  write_req_o, grant_o, write_ackn_o, write_done_o, data_rdy_o);
      end
      apply_reset();
   endtask

   task automatic test_single();
      apply_reset();
      req_i                = 2'b01;
      start_addr_i[37:0]   = 38'h100;
      burst_size_i[7:0]    = 8'd16;
      step();
      checks++;
      if (write_req_o !== 1'b1 || grant_o !== 2'b01) begin
         errors++; $display("FAIL single_grant got req=%0b grant=%b exp req=1 grant=01", write_req_o, grant_o);
      end
      checks++;
      if (write_start_addr_o !== 38'h100 || burst_size_o !== 8'd16) begin
         errors++; $display("FAIL single_addr got addr=%h burst=%0d exp addr=100 burst=16", write_start_addr_o, burst_size_o);
      end
      write_ackn_i = 1'b1;
      #1;
      checks++;
      if (write_ackn_o !== 2'b01) begin
         errors++; $display("FAIL single_ack got=%b exp=01", write_ackn_o);
      end
      step();
      write_ackn_i = 1'b0;
      req_i        = '0;   // dropping the request mid-burst must not cancel it
      #1;
      checks++;
      if (write_req_o !== 1'b0 || grant_o !== 2'b01) begin
         errors++; $display("FAIL single_burst got req=%0b grant=%b exp req=0 grant=01", write_req_o, grant_o);
      end
      write_done_i = 1'b1;
      #1;
      checks++;
      if (write_done_o !== 2'b01) begin
         errors++; $display("FAIL single_done got=%b exp=01", write_done_o);
      end
      step();
      write_done_i = 1'b0;
      #1;
      checks++;
      if (grant_o !== 2'b00 || write_done_o !== 2'b00) begin
         errors++; $display("FAIL single_idle got grant=%b done=%b exp 00/00", grant_o, write_done_o);
      end
   endtask

   task automatic test_back_to_back();
      int exp;
      apply_reset();
      start_addr_i = {38'h2000, 38'h1000};
      burst_size_i = {8'd8, 8'd4};
      req_i        = 2'b11;
      step();
      for (int b = 0; b < 4; b++) begin
         exp = rr_next(req_i, m_last);
         checks++;
         if (grant_o !== onehot(exp) || write_req_o !== 1'b1 ||
             write_start_addr_o !== start_addr_i[38*exp +: 38]) begin
            errors++;
            $display("FAIL b2b_grant%0d got grant=%b req=%0b addr=%h exp grant=%b req=1 addr=%h",
                     b, grant_o, write_req_o, write_start_addr_o, onehot(exp), start_addr_i[38*exp +: 38]);
         end
         write_ackn_i = 1'b1;
         step();
         write_ackn_i = 1'b0;
         step();
         write_done_i = 1'b1;
         step();
         write_done_i = 1'b0;
         m_last = exp;
         checks++;
         if (write_req_o !== 1'b0 || grant_o !== '0) begin
            errors++; $display("FAIL b2b_gap%0d got req=%0b grant=%b exp req=0 grant=00", b, write_req_o, grant_o);
         end
         step();
      end
   endtask

   task automatic test_ack_done_same();
      apply_reset();
      req_i = 2'b01;
      step();
      write_ackn_i = 1'b1;
      write_done_i = 1'b1;
      #1;
      checks++;
      if (write_ackn_o !== 2'b01 || write_done_o !== 2'b01) begin
         errors++; $display("FAIL same_pulses got ack=%b done=%b exp 01/01", write_ackn_o, write_done_o);
      end
      step();
      write_ackn_i = 1'b0;
      write_done_i = 1'b0;
      req_i        = '0;
      #1;
      checks++;
      if (write_req_o !== 1'b0 || grant_o !== 2'b00) begin
         errors++; $display("FAIL same_idle got req=%0b grant=%b exp 0/00", write_req_o, grant_o);
      end
      step();
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL same_stay got grant=%b exp=00", grant_o);
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      req_i = 2'b11;
      step();                       // grant edge
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL to_grant got=%b exp=01", grant_o);
      end
      write_ackn_i = 1'b1;
      step();                       // grant edge + 1
      write_ackn_i = 1'b0;
      for (int i = 2; i <= 14; i++) step();
      checks++;
      if (timeout_o !== 1'b0) begin
         errors++; $display("FAIL to_early got=%0b exp=0 at grant+14", timeout_o);
      end
      step();                       // grant edge + 15
      checks++;
      if (timeout_o !== 1'b1 || grant_o !== 2'b01) begin
         errors++; $display("FAIL to_pulse got to=%0b grant=%b exp 1/01 at grant+15", timeout_o, grant_o);
      end
      step();
      m_last = 0;
      checks++;
      if (timeout_o !== 1'b0 || grant_o !== 2'b00 || write_req_o !== 1'b0) begin
         errors++; $display("FAIL to_release got to=%0b grant=%b req=%0b exp 0/00/0", timeout_o, grant_o, write_req_o);
      end
      step();
      checks++;
      if (grant_o !== onehot(rr_next(req_i, m_last))) begin
         errors++; $display("FAIL to_next got=%b exp=%b", grant_o, onehot(rr_next(req_i, m_last)));
      end
   endtask

   task automatic test_data_mux();
      logic [DW-1:0] pat_a;
      logic [DW-1:0] pat_5;
      pat_a = {(DW/32){32'hAAAA_AAAA}};
      pat_5 = {(DW/32){32'h5555_5555}};
      apply_reset();
      data_i     = {pat_5, pat_a};
      data_rdy_i = 2'b11;
      #1;
      checks++;
      if (data_o !== '0 || data_rdy_o !== 1'b0) begin
         errors++; $display("FAIL mux_idle got data=%h.. rdy=%0b exp 0/0", data_o[31:0], data_rdy_o);
      end
      req_i = 2'b10;
      step();
      checks++;
      if (data_o !== pat_5) begin
         errors++; $display("FAIL mux_ch1 got=%h.. exp=%h..", data_o[31:0], pat_5[31:0]);
      end
      data_rdy_i = 2'b10;
      #1;
      checks++;
      if (data_rdy_o !== 1'b1) begin
         errors++; $display("FAIL mux_rdy_hi got=%0b exp=1", data_rdy_o);
      end
      data_rdy_i = 2'b01;
      #1;
      checks++;
      if (data_rdy_o !== 1'b0) begin
         errors++; $display("FAIL mux_rdy_lo got=%0b exp=0", data_rdy_o);
      end
      req_i        = '0;
      write_ackn_i = 1'b1;
      step();
      write_ackn_i = 1'b0;
      write_done_i = 1'b1;
      step();
      write_done_i = 1'b0;
      #1;
      checks++;
      if (data_o !== '0) begin
         errors++; $display("FAIL mux_after got=%h.. exp=0", data_o[31:0]);
      end
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      req_i        = 2'b10;
      start_addr_i = {38'h3F_0000_0000, 38'h55};
      burst_size_i = {8'd200, 8'd3};
      step();
      write_ackn_i = 1'b1;
      step();
      write_ackn_i = 1'b0;
      rstn_i       = 1'b0;
      #1;
      checks++;
      if ({write_req_o, grant_o, burst_size_o, write_start_addr_o, data_rdy_o,
           write_ackn_o, write_done_o, timeout_o} !== '0 || data_o !== '0) begin
         errors++;
         $display("FAIL rst_mid got grant=%b burst=%0d addr=%h exp all zero", grant_o, burst_size_o, write_start_addr_o);
      end
      step();
      rstn_i = 1'b1;
      m_last = N - 1;
      req_i  = 2'b11;
      step();
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL rst_first got=%b exp=01", grant_o);
      end
   endtask

   task automatic test_random();
      int exp, d, e;
      bit same;
      logic [37:0]   ea;
      logic [7:0]    eb;
      logic [DW-1:0] ed;
      apply_reset();
      for (int it = 0; it < 40; it++) begin
         req_i      = N'($urandom_range(0, (1 << N) - 1));
         data_rdy_i = N'($urandom());
         for (int k = 0; k < N; k++) begin
            start_addr_i[38*k +: 38] = {6'($urandom()), 32'($urandom())};
            burst_size_i[8*k +: 8]   = 8'($urandom());
         end
         for (int w = 0; w < DW*N/32; w++) data_i[32*w +: 32] = $urandom();
         if (it % 5 == 0) begin
            write_ackn_i = 1'b1;
            write_done_i = 1'b1;
            #1;
            checks++;
            if (write_ackn_o !== '0 || write_done_o !== '0) begin
               errors++; $display("FAIL rnd_stray%0d got ack=%b done=%b exp 00/00", it, write_ackn_o, write_done_o);
            end
            write_ackn_i = 1'b0;
            write_done_i = 1'b0;
         end
         exp = rr_next(req_i, m_last);
         if (exp >= 0) begin
            ea = start_addr_i[38*exp +: 38];
            eb = burst_size_i[8*exp +: 8];
            ed = data_i[DW*exp +: DW];
         end
         step();
         if (exp < 0) begin
            checks++;
            if (grant_o !== '0 || write_req_o !== 1'b0) begin
               errors++; $display("FAIL rnd_none%0d got grant=%b req=%0b exp 00/0", it, grant_o, write_req_o);
            end
            continue;
         end
         checks++;
         if (grant_o !== onehot(exp) || write_req_o !== 1'b1 || write_start_addr_o !== ea ||
             burst_size_o !== eb || data_o !== ed ||
             data_rdy_o !== (((int'(data_rdy_i) >> exp) & 1) == 1)) begin
            errors++;
            $display("FAIL rnd_grant%0d got grant=%b addr=%h burst=%0d exp grant=%b addr=%h burst=%0d",
                     it, grant_o, write_start_addr_o, burst_size_o, onehot(exp), ea, eb);
         end
         req_i = N'($urandom());
         for (int k = 0; k < N; k++) start_addr_i[38*k +: 38] = {6'($urandom()), 32'($urandom())};
         d = $urandom_range(0, 3);
         repeat (d) step();
         checks++;
         if (write_req_o !== 1'b1 || write_start_addr_o !== ea) begin
            errors++; $display("FAIL rnd_hold%0d got req=%0b addr=%h exp 1/%h", it, write_req_o, write_start_addr_o, ea);
         end
         same         = ($urandom_range(0, 3) == 0);
         write_ackn_i = 1'b1;
         write_done_i = same;
         #1;
         checks++;
         if (write_ackn_o !== onehot(exp) || write_done_o !== (same ? onehot(exp) : '0)) begin
            errors++; $display("FAIL rnd_ack%0d got ack=%b done=%b exp ack=%b same=%0b", it, write_ackn_o, write_done_o, onehot(exp), same);
         end
         step();
         write_ackn_i = 1'b0;
         write_done_i = 1'b0;
         if (!same) begin
            e = $urandom_range(0, 4);
            repeat (e) step();
            checks++;
            if (write_req_o !== 1'b0 || grant_o !== onehot(exp)) begin
               errors++; $display("FAIL rnd_burst%0d got req=%0b grant=%b exp 0/%b", it, write_req_o, grant_o, onehot(exp));
            end
            write_done_i = 1'b1;
            #1;
            checks++;
            if (write_done_o !== onehot(exp)) begin
               errors++; $display("FAIL rnd_done%0d got=%b exp=%b", it, write_done_o, onehot(exp));
            end
            step();
            write_done_i = 1'b0;
         end
         #1;
         checks++;
         if (grant_o !== '0 || timeout_o !== 1'b0) begin
            errors++; $display("FAIL rnd_end%0d got grant=%b to=%0b exp 00/0", it, grant_o, timeout_o);
         end
         m_last = exp;
      end
   endtask

   initial begin
      req_i        = '0;
      burst_size_i = '0;
      start_addr_i = '0;
      data_i       = '0;
      data_rdy_i   = '0;
      write_ackn_i = 1'b0;
      write_done_i = 1'b0;
      rstn_i       = 1'b0;
      m_last       = N - 1;
      test_reset();
      test_single();
      test_back_to_back();
      test_ack_done_same();
      test_timeout();
      test_data_mux();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL sim_watchdog time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/ddr_write_arbiter.md
# ddr_write_arbiter

Round-robin arbiter that shares one DDR native write port between g_NUM_REQ write channels (one frame-write pipeline per video/camera stream). Each channel presents a write request with start address and burst size. The arbiter grants one channel at a time, forwards its request to the DDR controller, routes acknowledge/done back to it, and muxes that channel's FIFO read data onto the shared port. A watchdog recovers the port if a burst never completes.

## Interface
- g_NUM_REQ, 2, number of write channels (2..4)
- g_DDR_AXI_DWIDTH, 512, write data width
- g_TIMEOUT, 4096, cycles allowed from grant to write_done_i before forced release
- sys_clk_i  input  1  DDR-domain clock; single clock, all logic on rising edge
- rstn_i  input  1  asynchronous active-low reset
- req_i  input  g_NUM_REQ  per-channel write request, level, held until its write_ackn_o
- burst_size_i  input  8*g_NUM_REQ  per-channel burst length (beats), slice k = [8k+7:8k]
- start_addr_i  input  38*g_NUM_REQ  per-channel DDR start address
- data_i  input  g_DDR_AXI_DWIDTH*g_NUM_REQ  per-channel FIFO read data
- data_rdy_i  input  g_NUM_REQ  per-channel FIFO data-ready
- write_ackn_i  input  1  DDR controller accept pulse
- write_done_i  input  1  DDR controller burst-complete pulse
- write_req_o  output  1  shared request to DDR controller
- burst_size_o  output  8  granted burst length
- write_start_addr_o  output  38  granted start address
- data_o  output  g_DDR_AXI_DWIDTH  granted channel data
- data_rdy_o  output  1  granted channel data-ready
- write_ackn_o  output  g_NUM_REQ  accept pulse routed to granted channel
- write_done_o  output  g_NUM_REQ  done pulse routed to granted channel
- grant_o  output  g_NUM_REQ  one-hot current grant, 0 when idle
- timeout_o  output  1  one-cycle pulse on watchdog expiry

## Operation
- FSM states: IDLE, REQ, BURST.
- IDLE: if any req_i bit set, select first set bit searching from last_grant+1 upward with wrap; register grant index, burst_size_o, write_start_addr_o; assert write_req_o; go REQ. No request: stay.
- REQ: write_req_o held high. On write_ackn_i: write_ackn_o[g] = 1 same cycle (combinational AND with grant), write_req_o low next cycle, go BURST. If write_done_i also arrives in the same cycle: forward both, go IDLE.
- BURST: on write_done_i: write_done_o[g] = 1 same cycle, last_grant <= g, go IDLE.
- A channel dropping req_i while in REQ/BURST is ignored; the grant completes normally.
- ackn/done arriving in IDLE are dropped; no channel sees them.
- Watchdog: counter cleared on entry to REQ, increments in REQ and BURST. At count == g_TIMEOUT-1 without done: timeout_o pulse, write_req_o low, last_grant <= g, go IDLE. A done arriving in the same cycle wins; no timeout.
- data_o/data_rdy_o: combinational mux by grant index in REQ and BURST; zero in IDLE.
- Counter width $clog2(g_TIMEOUT)+1; start address and burst size passed unmodified.

## Timing
- Reset: all outputs 0; state IDLE; last_grant = g_NUM_REQ-1 so channel 0 wins first; counter 0.
- Grant latency: req_i sampled high at edge N -> grant_o, write_req_o, address and burst valid after edge N.
- Back-to-back: done at edge M -> IDLE after M; next grant after M+1. Minimum 1 idle cycle between bursts.
- Address/burst outputs are registered and stable from grant until next grant.
- Data path: zero-cycle mux; data_rdy_i to data_rdy_o is combinational.
- Reset mid-burst: immediate return to reset values; the DDR controller and channels are reset by the same rstn_i.

## Structure
- Package ddr_write_arb_pkg: state enum (IDLE, REQ, BURST), constants C_ADDR_W = 38, C_BURST_W = 8.
- Sub-module rr_priority_select: combinational round-robin picker (req vector and last index in; valid and index out), reusable by the read-side arbiter.

## Test plan
- Reset, then req_i = 01, addr0 = 0x100, burst 16 -> write_req_o high 1 cycle later, write_start_addr_o = 0x100, burst_size_o = 16; ackn -> write_ackn_o = 01; done -> write_done_o = 01, grant_o = 0.
- req_i = 11 held for four bursts -> grant order 0,1,0,1, with one idle cycle between done and the next write_req_o.
- write_ackn_i and write_done_i in the same cycle in REQ -> both pulses forwarded, state IDLE next cycle.
- g_TIMEOUT = 16, ackn but no done -> timeout_o pulse 15 cycles after the grant cycle; next grant goes to the other channel.
- data_i per channel distinct (0xA…A / 0x5…5), channel 1 granted -> data_o = 0x5…5 and data_rdy_o follows data_rdy_i[1]; in IDLE data_o = 0.
- rstn_i low during BURST -> all outputs 0 immediately; after release, channel 0 is granted first.
